// File: rtl/pc_pkg.sv
// Shared types for program_counter_hs: handshake FSM states and next-PC op encodings.
package pc_pkg;

    // Four-phase output handshake states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RTZ  = 2'd2
    } pc_state_t;

    // Next-PC operation encodings presented on op
    localparam logic [1:0] PC_OP_INC  = 2'b00;
    localparam logic [1:0] PC_OP_LOAD = 2'b01;
    localparam logic [1:0] PC_OP_CALL = 2'b10;
    localparam logic [1:0] PC_OP_RET  = 2'b11;

endpackage

// File: rtl/program_counter_hs_if.sv
// Bus between the control unit / fetch stage and program_counter_hs.
// master: the program counter itself; slave: the control/fetch side.
interface program_counter_hs_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned INC_W = 2
);
    logic [1:0]       op;
    logic [INC_W-1:0] inc;
    logic [WIDTH-1:0] ld_addr;
    logic [WIDTH-1:0] data_out;
    logic             out_req;
    logic             ack_in;
    logic             ovf;
    logic             ras_err;

    modport master (
        input  op, inc, ld_addr, ack_in,
        output data_out, out_req, ovf, ras_err
    );

    modport slave (
        output op, inc, ld_addr, ack_in,
        input  data_out, out_req, ovf, ras_err
    );
endinterface

// File: rtl/pc_ras.sv
// Return-address stack: circular LIFO. A push into a full stack overwrites the
// oldest entry (the count saturates); a pop of an empty stack is ignored.
module pc_ras #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] top_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [CntW-1:0]  cnt_q, cnt_d;

    assign ptr_inc = (ptr_q == LastIdx) ? '0 : ptr_q + 1'b1;
    assign ptr_dec = (ptr_q == '0) ? LastIdx : ptr_q - 1'b1;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign top_o   = mem_q[ptr_q];

    // Pointer tracks the top entry; push has priority over pop
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i) begin
            ptr_d = ptr_inc;
            if (!full_o) cnt_d = cnt_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_dec;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= LastIdx;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents beyond the count are don't-care so no reset
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i) mem_q[ptr_inc] <= data_i;
    end
endmodule

// File: rtl/program_counter_hs.sv
// Clocked program counter with four-phase req/ack output handshake.
// Optional return-address stack enabled by defining PC_RAS_EN.
module program_counter_hs
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned INC_W     = 2,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    program_counter_hs_if.master pc_bus
);
    localparam logic [WIDTH-1:0] ResetPc = WIDTH'(RESET_VAL);

    pc_state_t        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             ovf_q, ovf_d;
    logic             advance;
    logic [WIDTH:0]   inc_sum;

    assign inc_sum = {1'b0, pc_q} + (WIDTH + 1)'(pc_bus.inc);

`ifdef PC_RAS_EN
    logic             err_q, err_d;
    logic             ras_push, ras_pop, ras_full, ras_empty;
    logic [WIDTH-1:0] ras_top;
    logic [WIDTH:0]   ret_sum;

    assign ret_sum = {1'b0, pc_q} + 1'b1;

    pc_ras #(
        .Width (WIDTH),
        .Depth (RAS_DEPTH)
    ) u_ras (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (ret_sum[WIDTH-1:0]),
        .top_o   (ras_top),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    assign pc_bus.ras_err = err_q;
`else
    // Stack depth is meaningless without the stack
    logic unused_ras_depth;
    assign unused_ras_depth = ^RAS_DEPTH;
    assign pc_bus.ras_err   = 1'b0;
`endif

    // Handshake FSM: advance happens only on the S_REQ edge that sees ack high
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (pc_bus.ack_in) begin
                    state_d = S_RTZ;
                    advance = 1'b1;
                end
            end
            S_RTZ:   if (!pc_bus.ack_in) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // Next-PC mux and flag updates, applied only on an advance
    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q;
`ifdef PC_RAS_EN
        err_d    = err_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
`endif
        if (advance) begin
            unique case (pc_bus.op)
                PC_OP_INC: begin
                    pc_d  = inc_sum[WIDTH-1:0];
                    ovf_d = inc_sum[WIDTH];
                end
                PC_OP_LOAD: begin
                    pc_d  = pc_bus.ld_addr;
                    ovf_d = 1'b0;
                end
`ifdef PC_RAS_EN
                PC_OP_CALL: begin
                    pc_d     = pc_bus.ld_addr;
                    ovf_d    = ret_sum[WIDTH];
                    ras_push = 1'b1;
                    if (ras_full) err_d = 1'b1;
                end
                PC_OP_RET: begin
                    ovf_d = 1'b0;
                    if (ras_empty) begin
                        pc_d  = ResetPc;
                        err_d = 1'b1;
                    end else begin
                        pc_d    = ras_top;
                        ras_pop = 1'b1;
                    end
                end
`else
                PC_OP_CALL: begin
                    pc_d  = pc_bus.ld_addr;
                    ovf_d = 1'b0;
                end
                PC_OP_RET: begin
                    pc_d  = inc_sum[WIDTH-1:0];
                    ovf_d = inc_sum[WIDTH];
                end
`endif
                default: ;
            endcase
        end
    end

    // State, PC and flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= ResetPc;
            ovf_q   <= 1'b0;
`ifdef PC_RAS_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
`ifdef PC_RAS_EN
            err_q   <= err_d;
`endif
        end
    end

    assign pc_bus.data_out = pc_q;
    assign pc_bus.out_req  = (state_q == S_REQ);
    assign pc_bus.ovf      = ovf_q;
endmodule

// File: tb/tb_program_counter_hs.sv
// Scoreboard bench for program_counter_hs: the driver pushes the expected PC/flags
// for each presentation; a monitor pops and compares on every out_req rise.
module tb_program_counter_hs;
    import pc_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned IW = 2;
    localparam int unsigned RV = 0;
    localparam int unsigned RD = 2;
    localparam int          MOD = 1 << W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    program_counter_hs_if #(.WIDTH(W), .INC_W(IW)) bus ();

    program_counter_hs #(
        .WIDTH     (W),
        .INC_W     (IW),
        .RESET_VAL (RV),
        .RAS_DEPTH (RD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pc_bus (bus)
    );

    typedef struct {
        int pc;
        bit ovf;
        bit err;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model state
    int m_pc;
    bit m_ovf;
    bit m_err;
    int m_stack[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.pc  = m_pc;
        e.ovf = m_ovf;
        e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_pc  = RV;
        m_ovf = 1'b0;
        m_err = 1'b0;
        m_stack.delete();
        exp_q.delete();
        push_expect();
    endtask

    task automatic model_inc(input int incv);
        int s;
        s     = m_pc + incv;
        m_ovf = (s >= MOD);
        m_pc  = s % MOD;
    endtask

    task automatic model_advance(input logic [1:0] op, input int incv, input int addr);
        case (op)
            PC_OP_INC: model_inc(incv);
            PC_OP_LOAD: begin
                m_pc  = addr;
                m_ovf = 1'b0;
            end
`ifdef PC_RAS_EN
            PC_OP_CALL: begin
                int r;
                r     = m_pc + 1;
                m_ovf = (r >= MOD);
                m_stack.push_back(r % MOD);
                if (m_stack.size() > RD) begin
                    void'(m_stack.pop_front());
                    m_err = 1'b1;
                end
                m_pc = addr;
            end
            default: begin
                m_ovf = 1'b0;
                if (m_stack.size() == 0) begin
                    m_pc  = RV;
                    m_err = 1'b1;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end
`else
            PC_OP_CALL: begin
                m_pc  = addr;
                m_ovf = 1'b0;
            end
            default: model_inc(incv);
`endif
        endcase
        push_expect();
    endtask

    task automatic drive_junk();
        bus.op      = 2'($urandom_range(0, 3));
        bus.inc     = IW'($urandom_range(0, 3));
        bus.ld_addr = W'($urandom_range(0, MOD - 1));
    endtask

    // Monitor: compare at each out_req rise and require data_out stable while high
    logic       prev_req = 1'b0;
    logic [W-1:0] held_pc = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (bus.out_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_req", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("data_out", 32'(bus.data_out), 32'(e.pc));
                    check("ovf", 32'(bus.ovf), 32'(e.ovf));
                    check("ras_err", 32'(bus.ras_err), 32'(e.err));
                end
                held_pc = bus.data_out;
            end else if (bus.out_req && prev_req) begin
                check("data_out_stable", 32'(bus.data_out), 32'(held_pc));
            end
            prev_req = bus.out_req;
        end
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_req) begin
                ok = 1'b1;
                break;
            end
            drive_junk();
        end
        if (!ok) check("out_req_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_reset();
        check("out_req_in_reset", 32'(bus.out_req), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("out_req_2_after_release", 32'(bus.out_req), 32'd1);
    endtask

    // One full handshake; optionally reset while in S_RTZ
    task automatic do_txn(input logic [1:0] op, input int incv, input int addr, input int hold,
                          input bit rst_in_rtz);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        bus.op      = op;
        bus.inc     = IW'(incv);
        bus.ld_addr = W'(addr);
        bus.ack_in  = 1'b1;
        model_advance(op, incv, addr);
        @(negedge clk);
        check("out_req_fall", 32'(bus.out_req), 32'd0);
        check("ovf_at_advance", 32'(bus.ovf), 32'(m_ovf));
        check("ras_err_at_advance", 32'(bus.ras_err), 32'(m_err));
        drive_junk();
        if (rst_in_rtz) begin
            rst        = 1'b1;
            bus.ack_in = 1'b0;
            model_reset();
            @(negedge clk);
            check("rst_data_out", 32'(bus.data_out), 32'(RV));
            check("rst_out_req", 32'(bus.out_req), 32'd0);
            check("rst_ovf", 32'(bus.ovf), 32'd0);
            check("rst_ras_err", 32'(bus.ras_err), 32'd0);
            release_reset();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            drive_junk();
            check("no_second_advance", 32'(bus.out_req), 32'd0);
        end
        bus.ack_in = 1'b0;
    endtask

    initial begin
        bit ok;
        bus.ack_in = 1'b0;
        drive_junk();
        model_reset();
        repeat (3) @(negedge clk);
        release_reset();

        // Basic increments: 0,1,2,3
        for (int i = 0; i < 3; i++) do_txn(PC_OP_INC, 1, 0, 0, 1'b0);
        // Wrap detection then clear
        do_txn(PC_OP_LOAD, 0, 'hFE, 0, 1'b0);
        do_txn(PC_OP_INC, 3, 0, 0, 1'b0);
        do_txn(PC_OP_INC, 1, 0, 0, 1'b0);
        // Zero step re-issues the same PC
        do_txn(PC_OP_INC, 0, 0, 0, 1'b0);
        // Held ack gives a single advance
        do_txn(PC_OP_LOAD, 0, 'h40, 5, 1'b0);
        // Call/return sequence with overflow and underflow of a 2-deep stack
        do_txn(PC_OP_LOAD, 0, 'h05, 0, 1'b0);
        do_txn(PC_OP_CALL, 0, 'h10, 0, 1'b0);
        do_txn(PC_OP_CALL, 0, 'h20, 0, 1'b0);
        do_txn(PC_OP_CALL, 0, 'h30, 0, 1'b0);
        for (int i = 0; i < 3; i++) do_txn(PC_OP_RET, 2, 0, 0, 1'b0);
        // Reset during S_RTZ after a load
        do_txn(PC_OP_LOAD, 0, 'h80, 0, 1'b1);
        // Stack must be empty after reset
        do_txn(PC_OP_RET, 1, 0, 0, 1'b0);
        do_txn(PC_OP_CALL, 0, 'h33, 0, 1'b0);
        do_txn(PC_OP_RET, 2, 0, 0, 1'b0);
        do_txn(PC_OP_LOAD, 0, 'hFF, 0, 1'b0);
        do_txn(PC_OP_CALL, 0, 'h12, 0, 1'b0);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            do_txn(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 3)), 1'b0);
        end

        wait_req(ok);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks,
                 errors);
        $fatal(1, "watchdog expired");
    end
endmodule
